wave_column_scheduler: RTL and testbench
========================================

// Module: wave_column_scheduler
// PURPOSE
//  Sequences loudness-column writes into the single-port waveform framebuffer.
//  Accepts one ROWS-bit column from the audio level block via a valid/ack handshake.
//  Writes that column pixel-by-pixel at a wrapping head column, and services full-screen clear requests.
//  Sits between the audio level block and the framebuffer write port feeding the VGA scanner.
// PARAMETERS
//  ROWS  100  pixels per column (width of col_data)
//  COLS  160  framebuffer columns; head column wraps COLS-1 -> 0
//  X_W   8    column address width, >= clog2(COLS)
//  Y_W   7    row address width, >= clog2(ROWS)
// PORTS
//  clk         in   1     system clock
//  reset       in   1     synchronous, active-high
//  col_valid   in   1     level: col_data holds a new column
//  col_data    in   ROWS  column bitmap; bit y = pixel at row y (bit 0 = top)
//  clear_req   in   1     request full-screen clear (pulse or level)
//  col_ack     out  1     1-cycle pulse: column accepted (source's "seen")
//  fb_we       out  1     framebuffer write enable
//  fb_x        out  X_W   write column address
//  fb_y        out  Y_W   write row address
//  fb_pixel    out  1     write data
//  head_col    out  X_W   column the next accepted column will be written to
//  busy        out  1     high whenever state != IDLE
//  clear_done  out  1     1-cycle pulse at end of a clear
// BEHAVIOUR
//  Reset: state IDLE; col_ack, fb_we, fb_x, fb_y, fb_pixel, head_col, busy, clear_done = 0; pending_clear = 0.
//  All outputs registered.
//  States: IDLE, WRITE, CLEAR.
//  IDLE: pending_clear or clear_req -> CLEAR (x=0, y=0); clear has priority.
//    Else col_valid=1 -> latch col_data into shadow reg, col_ack=1 next cycle, -> WRITE with y=0.
//  WRITE: starts the cycle after acceptance. Each cycle drives fb_we=1, fb_x=head_col, fb_y=y, fb_pixel=shadow[y].
//    Runs ROWS consecutive cycles, y = 0..ROWS-1.
//    After y=ROWS-1: head_col <= (head_col==COLS-1) ? 0 : head_col+1; -> IDLE.
//  CLEAR: fb_we=1, fb_pixel=0; y inner loop 0..ROWS-1, x outer loop 0..COLS-1 (ROWS*COLS writes).
//    After the last write: head_col <= 0, clear_done pulse, -> IDLE.
//  Latency: acceptance edge -> first fb_we = 1 cycle. Minimum spacing of accepted columns = ROWS+1 cycles.
//  col_ack is never high while in IDLE after the ack cycle. A col_valid held high is accepted once per IDLE visit.
//    Source must drop or replace col_valid on col_ack.
//  clear_req during WRITE: sets pending_clear. The column completes all ROWS writes, then CLEAR runs before any new column.
//  clear_req during CLEAR: ignored (no second clear).
//  col_valid during WRITE/CLEAR: not accepted, no ack; source keeps holding.
//  fb_we is 0 in IDLE. fb_x/fb_y hold their last values when fb_we=0.
//  Reset mid-WRITE/CLEAR: next cycle fb_we=0, state IDLE, head_col=0, pending_clear dropped, partial writes left as-is.
//  Counters must not exceed ROWS-1/COLS-1. No arithmetic overflow permitted at X_W/Y_W.
// TESTING
//  1 reset, col_valid=1 with col_data bits 20..79 set -> single col_ack pulse; 100 fb_we cycles at fb_x=0, fb_y 0..99;
//    fb_pixel=1 only for y 20..79; head_col=1 after.
//  2 160 columns back-to-back -> head_col goes 159->0; 161st column written at fb_x=0.
//  3 clear_req pulse at y=50 of WRITE -> column finishes all 100 writes; then 16000 writes of 0; clear_done pulse; head_col=0.
//  4 clear_req and col_valid same IDLE cycle -> CLEAR first; col_ack only after clear_done; column then written at x=0.
//  5 reset asserted at y=40 -> next cycle fb_we=0, busy=0, head_col=0; next column writes x=0 starting y=0.
//  6 col_valid held high forever -> exactly one col_ack per 101 cycles; fb_we gaps of exactly 1 cycle.

Source files
------------

// File: rtl/wave_column_scheduler.sv
// Writes ROWS-pixel loudness columns into the waveform framebuffer at a wrapping head column,
// and sweeps the whole framebuffer to zero on clear requests.
module wave_column_scheduler #(
    parameter int ROWS = 100,
    parameter int COLS = 160,
    parameter int X_W  = 8,
    parameter int Y_W  = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            col_valid,
    input  logic [ROWS-1:0] col_data,
    input  logic            clear_req,
    output logic            col_ack,
    output logic            fb_we,
    output logic [X_W-1:0]  fb_x,
    output logic [Y_W-1:0]  fb_y,
    output logic            fb_pixel,
    output logic [X_W-1:0]  head_col,
    output logic            busy,
    output logic            clear_done,
    output logic [1:0]      dbg_state
);

    // Handshake: col_valid is a level; a column is taken only on a cycle spent in IDLE,
    // and col_ack pulses for exactly one cycle afterwards. The source then drops or replaces col_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    state_t          state_q;
    logic            pending_q;
    logic [ROWS-1:0] shadow_q;
    logic [X_W-1:0]  cx_q;
    logic [Y_W-1:0]  cy_q;
    logic [X_W-1:0]  head_q;
    logic            col_ack_q;
    logic            fb_we_q;
    logic [X_W-1:0]  fb_x_q;
    logic [Y_W-1:0]  fb_y_q;
    logic            fb_pixel_q;
    logic            busy_q;
    logic            clear_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            head_q       <= '0;
            col_ack_q    <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_pixel_q   <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            col_ack_q    <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    fb_we_q <= 1'b0;
                    // A clear (new or deferred) always wins over a waiting column.
                    if (pending_q || clear_req) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                        cx_q      <= '0;
                        cy_q      <= '0;
                    end else if (col_valid) begin
                        shadow_q  <= col_data;
                        col_ack_q <= 1'b1;
                        state_q   <= WRITE;
                        busy_q    <= 1'b1;
                        cy_q      <= '0;
                    end
                end
                WRITE: begin
                    fb_we_q    <= 1'b1;
                    fb_x_q     <= head_q;
                    fb_y_q     <= cy_q;
                    fb_pixel_q <= shadow_q[cy_q];
                    if (clear_req) begin
                        pending_q <= 1'b1;
                    end
                    if (cy_q == Y_LAST) begin
                        cy_q    <= '0;
                        head_q  <= (head_q == X_LAST) ? '0 : head_q + 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cy_q <= cy_q + 1'b1;
                    end
                end
                CLEAR: begin
                    fb_we_q    <= 1'b1;
                    fb_x_q     <= cx_q;
                    fb_y_q     <= cy_q;
                    fb_pixel_q <= 1'b0;
                    if (cy_q == Y_LAST) begin
                        cy_q <= '0;
                        if (cx_q == X_LAST) begin
                            cx_q         <= '0;
                            head_q       <= '0;
                            clear_done_q <= 1'b1;
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            cx_q <= cx_q + 1'b1;
                        end
                    end else begin
                        cy_q <= cy_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign col_ack    = col_ack_q;
    assign fb_we      = fb_we_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_pixel   = fb_pixel_q;
    assign head_col   = head_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wave_column_scheduler.sv
// Bench for wave_column_scheduler: a framebuffer-write reference model feeds an expected queue
// that a negedge monitor drains against every fb_we cycle.
module tb_wave_column_scheduler;
    localparam int ROWS = 100;
    localparam int COLS = 160;
    localparam int X_W  = 8;
    localparam int Y_W  = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic            col_valid;
    logic [ROWS-1:0] col_data;
    logic            clear_req;
    logic            col_ack;
    logic            fb_we;
    logic [X_W-1:0]  fb_x;
    logic [Y_W-1:0]  fb_y;
    logic            fb_pixel;
    logic [X_W-1:0]  head_col;
    logic            busy;
    logic            clear_done;
    logic [1:0]      dbg_state;

    wave_column_scheduler #(.ROWS(ROWS), .COLS(COLS), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .reset(reset), .col_valid(col_valid), .col_data(col_data),
        .clear_req(clear_req), .col_ack(col_ack), .fb_we(fb_we), .fb_x(fb_x),
        .fb_y(fb_y), .fb_pixel(fb_pixel), .head_col(head_col), .busy(busy),
        .clear_done(clear_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard state ----------------
    int compared = 0;
    int mismatched = 0;
    logic [15:0] exp_q[$];
    int m_head = 0;
    int clear_done_cnt = 0;
    bit gap_en = 1'b0;
    int gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: a column is ROWS writes at the head column, then head advances with wrap;
    // a clear is a column-major sweep of zeros over the whole screen, then head returns to 0.
    task automatic push_col(input logic [ROWS-1:0] d);
        for (int y = 0; y < ROWS; y++) exp_q.push_back({8'(m_head), 7'(y), d[y]});
        m_head = (m_head + 1) % COLS;
    endtask

    task automatic push_clear();
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++) exp_q.push_back({8'(x), 7'(y), 1'b0});
        m_head = 0;
    endtask

    function automatic logic [ROWS-1:0] rand_col();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[ROWS-1:0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        if (clear_done) clear_done_cnt++;
        if (fb_we) begin
            if (gap_en && gap > 0) check("fb_we_gap", gap, 1);
            gap = 0;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got %0h expected no write", {fb_x, fb_y, fb_pixel});
            end else begin
                e = exp_q.pop_front();
                check("fb_write{x,y,pix}", {fb_x, fb_y, fb_pixel}, e);
            end
        end else begin
            gap++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_col(input logic [ROWS-1:0] d, input bit keep, output int ack_cyc);
        int t = 0;
        col_data  = d;
        col_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!col_ack && t < 20000);
        ack_cyc = cycle;
        if (!col_ack) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout: got no col_ack expected col_ack within 20000 cycles");
        end else begin
            push_col(d);
        end
        if (!keep) col_valid = 1'b0;
    endtask

    task automatic wait_row(input int row);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(fb_we && fb_y == Y_W'(row)) && t < 500);
        if (t >= 500) begin
            compared++;
            mismatched++;
            $display("FAIL row_timeout: got no write at row %0d expected one", row);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        col_valid = 1'b0;
        clear_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_head = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ROWS-1:0] d;
        int a, prev, cd0, t;
        reset = 1'b1;
        col_valid = 1'b0;
        clear_req = 1'b0;
        col_data = '0;
        repeat (3) @(negedge clk);
        check("rst_col_ack", col_ack, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_x", fb_x, 0);
        check("rst_fb_y", fb_y, 0);
        check("rst_fb_pixel", fb_pixel, 0);
        check("rst_head_col", head_col, 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single column, rows 20..79 lit.
        d = '0;
        for (int y = 20; y <= 79; y++) d[y] = 1'b1;
        send_col(d, 1'b0, a);
        check("t1_busy_on_ack", busy, 1);
        check("t1_we_on_ack", fb_we, 0);
        @(negedge clk);
        check("t1_ack_single", col_ack, 0);
        check("t1_latency_we", fb_we, 1);
        wait_drain();
        check("t1_head", head_col, m_head);
        check("t1_busy_idle", busy, 0);

        // 160 back-to-back columns wrap the head, then a 161st lands at x=0.
        do_reset();
        prev = 0;
        for (int i = 0; i < COLS; i++) begin
            send_col(rand_col(), 1'b1, a);
            if (i > 0) check("t2_ack_spacing", a - prev, ROWS + 1);
            if (i == COLS - 1) check("t2_head_last", head_col, COLS - 1);
            prev = a;
        end
        col_valid = 1'b0;
        wait_drain();
        check("t2_head_wrap", head_col, 0);
        send_col(rand_col(), 1'b0, a);
        wait_drain();
        check("t2_head_after161", head_col, m_head);

        // Clear request in the middle of a column write.
        send_col(rand_col(), 1'b0, a);
        wait_row(50);
        clear_req = 1'b1;
        push_clear();
        cd0 = clear_done_cnt;
        @(negedge clk);
        clear_req = 1'b0;
        wait_drain();
        check("t3_clear_done_cnt", clear_done_cnt - cd0, 1);
        check("t3_head", head_col, 0);

        // Clear and column in the same IDLE cycle: clear first.
        d = rand_col();
        col_data = d;
        col_valid = 1'b1;
        clear_req = 1'b1;
        push_clear();
        cd0 = clear_done_cnt;
        @(negedge clk);
        clear_req = 1'b0;
        t = 0;
        while (!col_ack && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("t4_ack_seen", col_ack, 1);
        check("t4_clear_before_ack", clear_done_cnt - cd0, 1);
        if (col_ack) push_col(d);
        col_valid = 1'b0;
        wait_drain();
        check("t4_head", head_col, m_head);

        // Reset in the middle of a column.
        send_col(rand_col(), 1'b0, a);
        wait_row(40);
        reset = 1'b1;
        @(negedge clk);
        check("t5_we_after_rst", fb_we, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_head_after_rst", head_col, 0);
        reset = 1'b0;
        exp_q.delete();
        m_head = 0;
        send_col(rand_col(), 1'b0, a);
        wait_drain();
        check("t5_head", head_col, m_head);

        // col_valid held high: one ack per ROWS+1 cycles, one-cycle write gaps.
        d = rand_col();
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            send_col(d, 1'b1, a);
            if (k > 0) check("t6_ack_spacing", a - prev, ROWS + 1);
            prev = a;
            if (k == 0) begin
                repeat (2) @(negedge clk);
                gap_en = 1'b1;
            end
        end
        col_valid = 1'b0;
        wait_drain();
        gap_en = 1'b0;

        // Randomized column traffic with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            send_col(rand_col(), 1'b0, a);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_drain();
        check("rand_head", head_col, m_head);
        check("rand_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
